// File: rtl/axi_burst_loader_if.sv
// Bus bundle between the burst loader and its environment: the incoming word
// stream, the write/read burst handshakes toward the AXI burst master, and the
// status counters. The "master" modport is the loader's view and the "slave"
// modport is the view of the logic that drives it.
interface axi_burst_loader_if #(
   parameter int DATA_W = 32,
   parameter int BEATS  = 16
);
   logic [DATA_W-1:0]       s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic                    start_write_txn;
   logic [31:0]             write_base_addr;
   logic [DATA_W*BEATS-1:0] write_data;
   logic                    write_done;
   logic                    start_read_txn;
   logic [31:0]             read_base_addr;
   logic                    read_done;
   logic                    read_error;
   logic                    busy;
   logic [15:0]             burst_count;
   logic [15:0]             error_count;
   logic                    timeout;

   modport master (
      input  s_data, s_valid, write_done, read_done, read_error,
      output s_ready, start_write_txn, write_base_addr, write_data,
             start_read_txn, read_base_addr, busy, burst_count,
             error_count, timeout
   );

   modport slave (
      output s_data, s_valid, write_done, read_done, read_error,
      input  s_ready, start_write_txn, write_base_addr, write_data,
             start_read_txn, read_base_addr, busy, burst_count,
             error_count, timeout
   );
endinterface

// File: rtl/axi_burst_loader.sv
// Burst loader: packs BEATS stream words into one burst image, pulses
// start_write_txn with an auto-incrementing (wrapping) base address, waits for
// write_done with a timeout, and keeps burst/error/timeout status.
// Optional feature macro: VERIFY_READBACK_EN adds a readback pass (ISSUE_RD /
// WAIT_RD) after every completed write and makes error_count live.
module axi_burst_loader #(
   parameter int          DATA_W      = 32,
   parameter int          BEATS       = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h40000000,
   parameter logic [31:0] ADDR_SPAN   = 32'h00001000,
   parameter int          TIMEOUT_CYC = 1024
) (
   input logic                m00_axi_aclk,
   input logic                m00_axi_areset,
   axi_burst_loader_if.master bus
);

   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [31:0]      ADDR_STEP = 32'(BEATS * DATA_W / 8);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BEATS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

`ifdef VERIFY_READBACK_EN
   typedef enum logic [2:0] {FILL, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, ADVANCE} state_t;
`else
   typedef enum logic [2:0] {FILL, ISSUE_WR, WAIT_WR, ADVANCE} state_t;
`endif

   state_t                  state;
   state_t                  next_state;
   logic [IDX_W-1:0]        idx;
   logic [TMR_W-1:0]        tmr;
   logic [DATA_W*BEATS-1:0] image;
   logic [31:0]             addr;
   logic [15:0]             bursts;
   logic                    tmo_flag;

   // Decoded per-cycle actions from the FSM
   logic ready;
   logic wr_pulse;
   logic tmr_clr;
   logic tmr_inc;
   logic wr_ok;
   logic tmo_hit;
   logic adv;
`ifdef VERIFY_READBACK_EN
   logic        rd_pulse;
   logic        err_hit;
   logic [15:0] errors;
`endif

   // Counter increment that sticks at all-ones
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Step to the next burst address, folding back to BASE_ADDR past the span
   function automatic logic [31:0] wrap_addr(input logic [31:0] a);
      logic [32:0] stepped;
      logic [32:0] limit;
      stepped = {1'b0, a} + {1'b0, ADDR_STEP};
      limit   = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};
      return (stepped >= limit) ? BASE_ADDR : stepped[31:0];
   endfunction

   // State register
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) state <= FILL;
      else                state <= next_state;
   end

   // Next-state and per-state action decode; a done beats the terminal count
   always_comb begin
      next_state = state;
      ready      = 1'b0;
      wr_pulse   = 1'b0;
      tmr_clr    = 1'b0;
      tmr_inc    = 1'b0;
      wr_ok      = 1'b0;
      tmo_hit    = 1'b0;
      adv        = 1'b0;
`ifdef VERIFY_READBACK_EN
      rd_pulse   = 1'b0;
      err_hit    = 1'b0;
`endif
      case (state)
         FILL: begin
            ready = 1'b1;
            if (bus.s_valid && idx == LAST_IDX) next_state = ISSUE_WR;
         end
         ISSUE_WR: begin
            wr_pulse   = 1'b1;
            tmr_clr    = 1'b1;
            next_state = WAIT_WR;
         end
         WAIT_WR: begin
            if (bus.write_done) begin
               wr_ok = 1'b1;
`ifdef VERIFY_READBACK_EN
               next_state = ISSUE_RD;
`else
               next_state = ADVANCE;
`endif
            end else if (tmr == TMR_LAST) begin
               tmo_hit    = 1'b1;
               next_state = ADVANCE;
            end else begin
               tmr_inc = 1'b1;
            end
         end
`ifdef VERIFY_READBACK_EN
         ISSUE_RD: begin
            rd_pulse   = 1'b1;
            tmr_clr    = 1'b1;
            next_state = WAIT_RD;
         end
         WAIT_RD: begin
            if (bus.read_done) begin
               err_hit    = bus.read_error;
               next_state = ADVANCE;
            end else if (tmr == TMR_LAST) begin
               tmo_hit    = 1'b1;
               next_state = ADVANCE;
            end else begin
               tmr_inc = 1'b1;
            end
         end
`endif
         ADVANCE: begin
            adv        = 1'b1;
            next_state = FILL;
         end
         default: next_state = FILL;
      endcase
   end

   // Burst image capture, beat index, done timer, address and status counters
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset) begin
         idx      <= '0;
         tmr      <= '0;
         image    <= '0;
         addr     <= BASE_ADDR;
         bursts   <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (ready && bus.s_valid) begin
            image[idx*DATA_W +: DATA_W] <= bus.s_data;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
         end
         if (tmr_clr)      tmr <= '0;
         else if (tmr_inc) tmr <= tmr + 1'b1;
         if (wr_ok)   bursts   <= bursts + 16'd1;
         if (tmo_hit) tmo_flag <= 1'b1;
         if (adv) begin
            addr <= wrap_addr(addr);
            idx  <= '0;
         end
      end
   end

`ifdef VERIFY_READBACK_EN
   // Readback mismatch counter, saturating
   always_ff @(posedge m00_axi_aclk) begin
      if (m00_axi_areset)  errors <= '0;
      else if (err_hit)    errors <= sat_inc(errors);
   end

   assign bus.start_read_txn = rd_pulse;
   assign bus.error_count    = errors;
`else
   // Readback inputs have no consumer in this build
   logic unused_rd;
   assign unused_rd = &{1'b0, bus.read_done, bus.read_error, sat_inc(16'h0)};

   assign bus.start_read_txn = 1'b0;
   assign bus.error_count    = 16'h0;
`endif

   assign bus.s_ready         = ready;
   assign bus.start_write_txn = wr_pulse;
   assign bus.write_base_addr = addr;
   assign bus.read_base_addr  = addr;
   assign bus.write_data      = image;
   assign bus.busy            = (state != FILL);
   assign bus.burst_count     = bursts;
   assign bus.timeout         = tmo_flag;

endmodule

// File: tb/tb_axi_burst_loader.sv
// Directed/randomised bench for axi_burst_loader. The reference model tracks
// the expected burst image, the number of bursts issued (address is derived
// arithmetically from it), completed bursts, readback errors and timeout.
module tb_axi_burst_loader;
   localparam int          DATA_W = 32;
   localparam int          BEATS  = 16;
   localparam int          IMG_W  = DATA_W * BEATS;
   localparam logic [31:0] BASE   = 32'h40000000;
   localparam logic [31:0] SPAN   = 32'h00001000;
   localparam int          TMO    = 1024;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_burst_loader_if #(.DATA_W(DATA_W), .BEATS(BEATS)) bus ();

   axi_burst_loader #(
      .DATA_W(DATA_W), .BEATS(BEATS), .BASE_ADDR(BASE),
      .ADDR_SPAN(SPAN), .TIMEOUT_CYC(TMO)
   ) dut (
      .m00_axi_aclk  (clk),
      .m00_axi_areset(rst),
      .bus           (bus.master)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [IMG_W-1:0] img;
   int issued;
   int exp_bursts;
   int exp_errs;
   logic exp_tmo;

   function automatic logic [31:0] model_addr(input int n);
      longint off;
      off = (longint'(n) * BEATS * DATA_W / 8) % longint'(SPAN);
      return BASE + 32'(off);
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [IMG_W-1:0] obs, input logic [IMG_W-1:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      img        = '0;
      issued     = 0;
      exp_bursts = 0;
      exp_errs   = 0;
      exp_tmo    = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_ready",   bus.s_ready, 1);
      chk("rst_start_wr", bus.start_write_txn, 0);
      chk("rst_start_rd", bus.start_read_txn, 0);
      chk("rst_wr_addr", bus.write_base_addr, BASE);
      chk("rst_rd_addr", bus.read_base_addr, BASE);
      chk("rst_data",    bus.write_data, 0);
      chk("rst_busy",    bus.busy, 0);
      chk("rst_bursts",  bus.burst_count, 0);
      chk("rst_errors",  bus.error_count, 0);
      chk("rst_timeout", bus.timeout, 0);
   endtask

   // Stream n words (pattern i*8+3 or random) with up to max_gap idle cycles
   // before each; optionally pulse a stray write_done while filling.
   task automatic fill_words(input int n, input bit pattern, input int max_gap, input bit stray_done);
      int g;
      logic [DATA_W-1:0] w;
      for (int i = 0; i < n; i++) begin
         g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         repeat (g) begin
            bus.s_valid = 1'b0;
            bus.s_data  = $urandom;
            cyc();
         end
         w = pattern ? DATA_W'(i * 8 + 3) : DATA_W'($urandom);
         img[i*DATA_W +: DATA_W] = w;
         bus.s_data     = w;
         bus.s_valid    = 1'b1;
         bus.write_done = stray_done && (i == 1);
         if (i == 0) begin
            chk("fill_ready", bus.s_ready, 1);
            chk("fill_busy", bus.busy, 0);
         end
         cyc();
         bus.write_done = 1'b0;
      end
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
   endtask

   // Called in the cycle after the last beat was accepted
   task automatic check_issue();
      chk("start_wr",    bus.start_write_txn, 1);
      chk("wr_addr",     bus.write_base_addr, model_addr(issued));
      chk("wr_data",     bus.write_data, img);
      chk("busy_issue",  bus.busy, 1);
      chk("ready_issue", bus.s_ready, 0);
      issued++;
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      cyc();
      bus.s_valid = 1'b0;
      chk("start_wr_one", bus.start_write_txn, 0);
      chk("data_hold",    bus.write_data, img);
   endtask

   // Enter in the first WAIT_WR cycle; deliver write_done after delay cycles
   task automatic complete_write(input int delay, input bit err);
      repeat (delay) cyc();
      chk("addr_stable", bus.write_base_addr, model_addr(issued - 1));
      bus.write_done = 1'b1;
      bus.read_done  = 1'b1;
      bus.read_error = 1'b1;
      cyc();
      bus.write_done = 1'b0;
      bus.read_done  = 1'b0;
      bus.read_error = 1'b0;
      exp_bursts++;
      chk("burst_count", bus.burst_count, 16'(exp_bursts));
`ifdef VERIFY_READBACK_EN
      chk("start_rd",     bus.start_read_txn, 1);
      chk("rd_addr",      bus.read_base_addr, model_addr(issued - 1));
      chk("err_ignored",  bus.error_count, 16'(exp_errs));
      cyc();
      chk("start_rd_one", bus.start_read_txn, 0);
      repeat ($urandom_range(3, 0)) cyc();
      bus.read_done  = 1'b1;
      bus.read_error = err;
      cyc();
      bus.read_done  = 1'b0;
      bus.read_error = 1'b0;
      if (err) exp_errs++;
`else
      if (err) exp_errs = exp_errs;
`endif
      chk("ready_adv",   bus.s_ready, 0);
      chk("busy_adv",    bus.busy, 1);
      chk("error_count", bus.error_count, 16'(exp_errs));
      cyc();
      chk("ready_back",  bus.s_ready, 1);
      chk("busy_idle",   bus.busy, 0);
      chk("next_addr",   bus.write_base_addr, model_addr(issued));
      chk("rd_addr_idle", bus.read_base_addr, model_addr(issued));
      chk("start_rd_idle", bus.start_read_txn, 0);
      chk("timeout_keep", bus.timeout, exp_tmo);
   endtask

   initial begin
      rst            = 1'b1;
      bus.s_data     = '0;
      bus.s_valid    = 1'b0;
      bus.write_done = 1'b0;
      bus.read_done  = 1'b0;
      bus.read_error = 1'b0;
      model_reset();
      repeat (3) cyc();
      check_reset_state();
      rst = 1'b0;
      cyc();

      // Pattern burst, back-to-back words
      fill_words(BEATS, 1'b1, 0, 1'b0);
      chk("word0",  bus.write_data[31:0], 32'd3);
      chk("word15", bus.write_data[511:480], 32'd123);
      check_issue();
      complete_write(20, 1'b0);

      // Three random bursts with gaps and a stray done while filling
      for (int b = 0; b < 3; b++) begin
         fill_words(BEATS, 1'b0, 2, 1'b1);
         check_issue();
         complete_write(int'($urandom_range(30, 0)), 1'($urandom));
      end
      chk("four_bursts", bus.burst_count, 16'd4);
      chk("addr_after4", bus.write_base_addr, 32'h40000100);

      // Done arriving on the timeout terminal count wins
      fill_words(BEATS, 1'b0, 1, 1'b0);
      check_issue();
      complete_write(TMO - 1, 1'b0);
      chk("edge_no_timeout", bus.timeout, 0);

      // Withheld done: timeout after TMO cycles in WAIT_WR
      fill_words(BEATS, 1'b0, 0, 1'b0);
      check_issue();
      repeat (TMO - 1) cyc();
      chk("tmo_not_yet", bus.timeout, 0);
      chk("tmo_wait_ready", bus.s_ready, 0);
      cyc();
      exp_tmo = 1'b1;
      chk("tmo_set",    bus.timeout, 1);
      chk("tmo_bursts", bus.burst_count, 16'(exp_bursts));
      cyc();
      chk("tmo_ready",  bus.s_ready, 1);
      chk("tmo_addr",   bus.write_base_addr, model_addr(issued));

      // Run through the address span until it wraps
      while (issued < 66) begin
         fill_words(BEATS, 1'b0, 0, 1'b0);
         if (issued == 63) chk("wrap_last",  bus.write_base_addr, 32'h40000FC0);
         if (issued == 64) chk("wrap_first", bus.write_base_addr, 32'h40000000);
         check_issue();
         complete_write(int'($urandom_range(3, 0)), 1'($urandom));
      end

      // Reset in the middle of a fill
      fill_words(8, 1'b0, 1, 1'b0);
      rst = 1'b1;
      cyc();
      model_reset();
      check_reset_state();
      rst = 1'b0;
      cyc();
      chk("post_rst_start", bus.start_write_txn, 0);
      fill_words(BEATS, 1'b0, 1, 1'b0);
      check_issue();
      chk("post_rst_issued", issued, 1);
      complete_write(5, 1'b0);
      chk("post_rst_bursts", bus.burst_count, 16'd1);

`ifdef VERIFY_READBACK_EN
      // Readback errors on 2 of 3 bursts
      for (int b = 0; b < 3; b++) begin
         fill_words(BEATS, 1'b0, 1, 1'b0);
         check_issue();
         complete_write(int'($urandom_range(10, 0)), (b != 1));
      end
      chk("rd_errors", bus.error_count, 16'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
